sync_frame_tx: RTL and testbench



---
 rtl/sync_frame_pkg.sv | 17 +
 rtl/sync_frame_stuffer.sv | 24 ++
 rtl/sync_frame_tx.sv | 156 +++++++++++++++
 tb/tb_sync_frame_tx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_frame_pkg.sv
// Shared constants for the 1101 sync-pattern link: state encoding, sync marker, guard length, stuff trigger.
package sync_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GUARD   = 3'd1,
    SYNC    = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4
  } state_t;

  localparam logic [3:0] SYNC_PATTERN  = 4'b1101;
  localparam int         GUARD_LEN     = 2;
  // Last three line bits 1,1,0 (oldest first): a following 1 would complete 1101.
  localparam logic [2:0] STUFF_TRIGGER = 3'b110;

endpackage

// File: rtl/sync_frame_stuffer.sv
// History of the last three emitted line bits (newest in bit 0) and the stuff request derived from it.
module sync_frame_stuffer
  import sync_frame_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic en,
  output logic stuff_req
);

  logic [2:0] history_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_q <= 3'b000;
    end else if (en) begin
      history_q <= {history_q[1:0], bit_in};
    end
  end

  assign stuff_req = (history_q == STUFF_TRIGGER);

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: 00 guard, 1101 sync, MSB-first zero-stuffed payload.
// Optional trailing even-parity bit when SYNC_FRAME_TX_PARITY_EN is defined.
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              frame_active,
  output logic [2:0]        state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // state_q names the frame section of the bit currently on serial_out.
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        phase_q, phase_d;
  logic              serial_q, serial_d;
  logic              active_q, active_d;
  logic              emit;
  logic              pay_step;
  logic              stuff_req;
`ifdef SYNC_FRAME_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Handshake: a word transfers on a rising edge where data_valid and data_ready are both high;
  // data_ready depends only on state, data_valid/data_in are ignored whenever data_ready is low.
  assign data_ready   = (state_q == IDLE);
  assign serial_out   = serial_q;
  assign frame_active = active_q;
  assign state        = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      phase_q  <= 2'd0;
      serial_q <= 1'b0;
      active_q <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      serial_q <= serial_d;
      active_q <= active_d;
`ifdef SYNC_FRAME_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    serial_d = 1'b0;
    active_d = 1'b1;
    emit     = 1'b1;
    pay_step = 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        active_d = 1'b0;
        emit     = 1'b0;
        if (data_valid) begin
          // The acceptance edge already puts the first guard bit on the line.
          shift_d  = data_in;
          cnt_d    = '0;
          phase_d  = 2'd1;
          state_d  = GUARD;
          active_d = 1'b1;
          emit     = 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      GUARD: begin
        if (phase_q == 2'(GUARD_LEN)) begin
          serial_d = SYNC_PATTERN[3];
          phase_d  = 2'd1;
          state_d  = SYNC;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      SYNC: begin
        // phase wraps to 0 once all four marker bits have been sent.
        if (phase_q == 2'd0) begin
          pay_step = 1'b1;
        end else begin
          serial_d = SYNC_PATTERN[2'd3 - phase_q];
          phase_d  = phase_q + 2'd1;
        end
      end
      PAYLOAD: pay_step = 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
      PARITY: begin
        state_d  = IDLE;
        active_d = 1'b0;
        emit     = 1'b0;
      end
`endif
      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
        emit     = 1'b0;
      end
    endcase

    if (pay_step) begin
      state_d = PAYLOAD;
      if (cnt_q == CNT_W'(DATA_W)) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
        if (!stuff_req) begin
          serial_d = parity_q;
          state_d  = PARITY;
        end
`else
        state_d  = IDLE;
        active_d = 1'b0;
        emit     = 1'b0;
`endif
      end else if (!stuff_req) begin
        serial_d = shift_q[DATA_W-1];
        shift_d  = shift_q << 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end
  end

  sync_frame_stuffer u_stuffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (serial_d),
    .en        (emit),
    .stuff_req (stuff_req)
  );

endmodule

// File: tb/tb_sync_frame_tx.sv
// Self-checking bench for sync_frame_tx (honours SYNC_FRAME_TX_PARITY_EN when defined).
module tb_sync_frame_tx;

  localparam int DATA_W  = 8;
  localparam int MAX_CYC = 6 + 2 * DATA_W + 4;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              serial_out;
  logic              frame_active;
  logic [2:0]        state;

  int total;
  int bad;

  logic [0:0] exp_q[$];
  logic [0:0] obs_q[$];
  int         busy_seen;
  int         hits;
  int         hit_idx;
  logic [3:0] det;
  logic       offer_ready;
  logic       end_line;
  logic       end_active;
  logic [2:0] end_state;

  sync_frame_tx #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame built from the framing rules on a plain bit list.
  task automatic build_expected(input logic [DATA_W-1:0] w);
    int i;
    int n;
    exp_q.delete();
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    i = DATA_W - 1;
    while (i >= 0) begin
      n = exp_q.size();
      if (exp_q[n-3] == 1'b1 && exp_q[n-2] == 1'b1 && exp_q[n-1] == 1'b0) begin
        exp_q.push_back(1'b0);
      end else begin
        exp_q.push_back(w[i]);
        i--;
      end
    end
`ifdef SYNC_FRAME_TX_PARITY_EN
    n = exp_q.size();
    if (exp_q[n-3] == 1'b1 && exp_q[n-2] == 1'b1 && exp_q[n-1] == 1'b0)
      exp_q.push_back(1'b0);
    exp_q.push_back(^w);
`endif
  endtask

  // driver: offer one word, then capture the frame until frame_active drops
  task automatic run_frame(input logic [DATA_W-1:0] w);
    @(negedge clk);
    data_in     = w;
    data_valid  = 1'b1;
    offer_ready = data_ready;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_in    = DATA_W'($urandom);
    obs_q.delete();
    busy_seen = 0;
    hits      = 0;
    hit_idx   = -1;
    for (int i = 0; i < MAX_CYC; i++) begin
      @(negedge clk);
      det = {det[2:0], serial_out};
      if (det == 4'b1101) begin
        hits++;
        hit_idx = i;
      end
      if (!frame_active) break;
      obs_q.push_back(serial_out);
      if (data_ready) busy_seen++;
    end
    end_line   = serial_out;
    end_active = frame_active;
    end_state  = state;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (serial_out !== 1'b0 || frame_active !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs: got line=%b active=%b state=%0d want 0/0/0", serial_out, frame_active, state);
    end
    total++;
    if (data_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", data_ready);
    end
    @(negedge clk);
    data_valid = 1'b0;
    rst_n      = 1'b1;
    #1;
    total++;
    if (data_ready !== 1'b1 || state !== 3'd0) begin
      bad++;
      $display("FAIL release_idle: got ready=%b state=%0d want 1/0", data_ready, state);
    end
  endtask

  // scenario: one word against a caller-supplied exp_q
  task automatic test_frame(input string name, input logic [DATA_W-1:0] w);
    run_frame(w);
    total++;
    if (offer_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got %b want 1", name, offer_ready);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_len: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_bit%0d: got %b want %b", name, i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (busy_seen != 0) begin
      bad++;
      $display("FAIL %s_busy: data_ready high in %0d frame cycles want 0", name, busy_seen);
    end
    total++;
    if (hits != 1 || hit_idx != 5) begin
      bad++;
      $display("FAIL %s_detect: got hits=%0d at %0d want 1 at 5", name, hits, hit_idx);
    end
    total++;
    if (end_line !== 1'b0 || end_active !== 1'b0 || end_state !== 3'd0) begin
      bad++;
      $display("FAIL %s_end: got line=%b active=%b state=%0d want 0/0/0", name, end_line, end_active, end_state);
    end
  endtask

  task automatic test_zero_word;
    logic [13:0] bits;
    bits = 14'b00_1101_00000000;
    exp_q.delete();
    for (int i = 13; i >= 0; i--) exp_q.push_back(bits[i]);
`ifdef SYNC_FRAME_TX_PARITY_EN
    exp_q.push_back(1'b0);
`endif
    test_frame("zero", 8'h00);
  endtask

  task automatic test_stuffing;
    logic [15:0] bits;
    bits = 16'b00_1101_1100110011;
    exp_q.delete();
    for (int i = 15; i >= 0; i--) exp_q.push_back(bits[i]);
`ifdef SYNC_FRAME_TX_PARITY_EN
    exp_q.push_back(1'b0);
`endif
    test_frame("stuff_db", 8'hDB);
  endtask

  task automatic test_back_to_back;
    logic [0:0] seq_q[$];
    logic [0:0] act_q[$];
    int         len1;
    int         b2b_hits;
    build_expected(8'hFF);
    len1 = exp_q.size();
    for (int r = 0; r < 2; r++) begin
      foreach (exp_q[i]) begin
        seq_q.push_back(exp_q[i]);
        act_q.push_back(1'b1);
      end
      seq_q.push_back(1'b0);
      act_q.push_back(1'b0);
    end
    b2b_hits = 0;
    @(negedge clk);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    for (int i = 0; i < seq_q.size(); i++) begin
      @(negedge clk);
      det = {det[2:0], serial_out};
      if (det == 4'b1101) b2b_hits++;
      if (i == len1 + 1) data_valid = 1'b0;
      total++;
      if (serial_out !== seq_q[i] || frame_active !== act_q[i]) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got line=%b active=%b want %b/%b", i, serial_out, frame_active, seq_q[i], act_q[i]);
      end
    end
    total++;
    if (b2b_hits != 2) begin
      bad++;
      $display("FAIL b2b_detect: got %0d want 2", b2b_hits);
    end
  endtask

  task automatic test_reset_mid_frame;
    build_expected(8'hA5);
    @(negedge clk);
    data_in    = 8'hA5;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    total++;
    if (serial_out !== exp_q[6] || frame_active !== 1'b1) begin
      bad++;
      $display("FAIL mid_before: got line=%b active=%b want %b/1", serial_out, frame_active, exp_q[6]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (serial_out !== 1'b0 || frame_active !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset: got line=%b active=%b state=%0d want 0/0/0", serial_out, frame_active, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    det   = 4'b0000;
    @(negedge clk);
    total++;
    if (frame_active !== 1'b0 || data_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_resume: got active=%b ready=%b want 0/1", frame_active, data_ready);
    end
    build_expected(8'h3C);
    test_frame("after_reset_3c", 8'h3C);
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] rx_word;
    logic [2:0]        rx_hist;
    int                got;
    int                k;
    for (int n = 0; n < 1000; n++) begin
      w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      build_expected(w);
      run_frame(w);
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rand%0d_len: word=%h got %0d want %0d", n, w, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < obs_q.size(); i++) begin
          total++;
          if (obs_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rand%0d_bit%0d: word=%h got %b want %b", n, i, w, obs_q[i], exp_q[i]);
          end
        end
      end
      total++;
      if (hits != 1 || hit_idx != 5) begin
        bad++;
        $display("FAIL rand%0d_detect: word=%h got hits=%0d at %0d want 1 at 5", n, w, hits, hit_idx);
      end
      // receiver-side destuffing of the captured line bits
      rx_word = '0;
      rx_hist = 3'b101;
      got     = 0;
      k       = 6;
      while (k < obs_q.size() && got < DATA_W) begin
        if (rx_hist != 3'b110) begin
          rx_word = {rx_word[DATA_W-2:0], obs_q[k]};
          got++;
        end
        rx_hist = {rx_hist[1:0], obs_q[k]};
        k++;
      end
      total++;
      if (rx_word !== w || got != DATA_W) begin
        bad++;
        $display("FAIL rand%0d_rx: got %h (%0d bits) want %h", n, rx_word, got, w);
      end
`ifdef SYNC_FRAME_TX_PARITY_EN
      if (k < obs_q.size() && rx_hist == 3'b110) k++;
      total++;
      if (k >= obs_q.size() || obs_q[k] !== (^w)) begin
        bad++;
        $display("FAIL rand%0d_parity: word=%h want %b", n, w, ^w);
      end
`endif
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    det        = 4'b0000;
    rst_n      = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'h55;
    test_reset();
    test_zero_word();
    test_stuffing();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
